// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared core definitions for the stall/flush scheduler: FSM encodings,
// the x0 register index and the load-use hazard helper.
package pipeline_stall_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_X0 = 5'h00;

  // A load whose destination feeds either Decode source; x0 never carries data.
  function automatic logic load_use_hazard(input logic       mem_read,
                                           input logic [4:0] rd,
                                           input logic [4:0] rs1,
                                           input logic [4:0] rs2);
    return mem_read && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-unit bus: pipeline-side hazard inputs and the stall/flush/MD controls.
// No valid/ready here: every signal is a level valid for the current cycle, except
// MD_Start and MD_Done, which are single-cycle pulses forming the MUL/DIV handshake.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       RS1_D;
  logic [4:0]       RS2_D;
  logic [4:0]       Rd_E;
  logic             MemRead_E;
  logic             PCSrc_E;
  logic             MulDiv_E;
  logic             MD_Done;
  logic             Stall_F;
  logic             Stall_D;
  logic             Stall_E;
  logic             Flush_D;
  logic             Flush_E;
  logic             Flush_M;
  logic             MD_Start;
  logic             MD_Busy;
  logic             MD_Err;
  logic [CNT_W-1:0] Stall_Count;

  modport master (
    output RS1_D, RS2_D, Rd_E, MemRead_E, PCSrc_E, MulDiv_E, MD_Done,
    input  Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M,
           MD_Start, MD_Busy, MD_Err, Stall_Count
  );

  modport slave (
    input  RS1_D, RS2_D, Rd_E, MemRead_E, PCSrc_E, MulDiv_E, MD_Done,
    output Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M,
           MD_Start, MD_Busy, MD_Err, Stall_Count
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; reusable for perf counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush scheduler: load-use bubbles, branch flushes and the
// MUL/DIV start/done sequencing with timeout, plus a stall-cycle counter.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_stall_ctrl_if.slave bus,
  output md_state_e            fsm_state
);

  localparam int WAIT_W = $clog2(MD_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

  md_state_e        state;
  md_state_e        state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic             md_err;
  logic             timeout;
  logic             load_use;
  logic [CNT_W-1:0] cnt_q;
  logic             stall_f, stall_d, stall_e;
  logic             flush_d, flush_e, flush_m;
  logic             md_start;

  assign fsm_state = state;
  assign timeout   = (state == MD_WAIT) && !bus.MD_Done && (wait_cnt == WAIT_LAST);
  assign load_use  = load_use_hazard(bus.MemRead_E, bus.Rd_E, bus.RS1_D, bus.RS2_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      md_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        wait_cnt <= '0;
      end else if (!bus.MD_Done) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout) begin
        md_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.MulDiv_E && !bus.PCSrc_E) state_nx = MD_WAIT;
      MD_WAIT: if (bus.MD_Done || timeout)       state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Branch beats MUL/DIV launch beats load-use; nothing but MD_Done matters in MD_WAIT.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    md_start = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.PCSrc_E) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (bus.MulDiv_E) begin
            md_start = 1'b1;
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            flush_m  = 1'b1;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        MD_WAIT: begin
          if (!bus.MD_Done) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_f),
    .q   (cnt_q)
  );

  assign bus.Stall_F     = stall_f;
  assign bus.Stall_D     = stall_d;
  assign bus.Stall_E     = stall_e;
  assign bus.Flush_D     = flush_d;
  assign bus.Flush_E     = flush_e;
  assign bus.Flush_M     = flush_m;
  assign bus.MD_Start    = md_start;
  assign bus.MD_Busy     = !rst && (state == MD_WAIT);
  assign bus.MD_Err      = !rst && md_err;
  assign bus.Stall_Count = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench: each driven cycle pushes its hand-computed response into a queue;
// a negedge monitor pops and compares against the DUT outputs.
module tb_pipeline_stall_ctrl;
  import pipeline_stall_ctrl_pkg::*;

  localparam int CNT_W = 16;
  localparam int W     = 27;  // {state_chk, state, flags[8:0], count[15:0]}

  // flags: {Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, MD_Start, MD_Busy, MD_Err}
  localparam logic [8:0] NONE  = 9'b000_000_000;
  localparam logic [8:0] LU    = 9'b110_010_000;
  localparam logic [8:0] BR    = 9'b000_110_000;
  localparam logic [8:0] START = 9'b111_001_100;
  localparam logic [8:0] WAITS = 9'b111_001_010;
  localparam logic [8:0] DONE  = 9'b000_000_010;
  localparam logic [8:0] ERR   = 9'b000_000_001;

  logic      clk = 1'b0;
  logic      rst;
  md_state_e fsm_state;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(.MD_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic step(input logic rst_in, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic mem, input logic pc, input logic md,
                      input logic done, input logic st_chk, input logic st,
                      input logic [8:0] flags, input logic [15:0] cnt, input string name);
    @(posedge clk);
    #1;
    rst           = rst_in;
    bus.RS1_D     = rs1;
    bus.RS2_D     = rs2;
    bus.Rd_E      = rd;
    bus.MemRead_E = mem;
    bus.PCSrc_E   = pc;
    bus.MulDiv_E  = md;
    bus.MD_Done   = done;
    exp_q.push_back({st_chk, st, flags, cnt});
    name_q.push_back(name);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {e[26], (e[26] ? fsm_state : e[25]),
           bus.Stall_F, bus.Stall_D, bus.Stall_E, bus.Flush_D, bus.Flush_E, bus.Flush_M,
           bus.MD_Start, bus.MD_Busy, bus.MD_Err, bus.Stall_Count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got state=%b flags=%b cnt=%0d, expected state=%b flags=%b cnt=%0d",
                 n, a[25], a[24:16], a[15:0], e[25], e[24:16], e[15:0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.RS1_D = '0; bus.RS2_D = '0; bus.Rd_E = '0;
    bus.MemRead_E = 1'b0; bus.PCSrc_E = 1'b0; bus.MulDiv_E = 1'b0; bus.MD_Done = 1'b0;

    //   rst rs1 rs2 rd mem pc md dn chk st flags        cnt
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 16'd0, "reset0");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 16'd0, "reset1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 16'd0, "idle");
    // load-use on rs1, then rs2
    step(0, 5, 1, 5, 1, 0, 0, 0, 1, 0, LU,   16'd0, "lu_rs1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 16'd1, "lu_rs1_after");
    step(0, 3, 9, 9, 1, 0, 0, 0, 1, 0, LU,   16'd1, "lu_rs2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 16'd2, "lu_rs2_after");
    step(0, 5, 0, 5, 0, 0, 0, 0, 1, 0, NONE, 16'd2, "no_load");
    step(0, 3, 0, 0, 1, 0, 0, 0, 1, 0, NONE, 16'd2, "lu_x0");
    step(0, 5, 6, 4, 1, 0, 0, 0, 1, 0, NONE, 16'd2, "lu_nomatch");
    // branch priority
    step(0, 7, 0, 7, 1, 1, 0, 0, 1, 0, BR,   16'd2, "br_over_lu");
    step(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, BR,   16'd2, "br_over_md");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 16'd2, "br_after");
    // MUL/DIV handshake, done on cycle 4
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, START, 16'd2, "md_c0");
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, WAITS, 16'd3, "md_c1");
    step(0, 7, 0, 7, 1, 1, 1, 0, 1, 1, WAITS, 16'd4, "md_c2_ignore");
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, WAITS, 16'd5, "md_c3");
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, DONE,  16'd6, "md_c4_done");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE,  16'd6, "md_after");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, NONE,  16'd6, "done_in_idle");
    // timeout: launch + 8 wait cycles, no MD_Done
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, START, 16'd6, "to_launch");
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, WAITS, 16'(7 + i), "to_wait");
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ERR,      16'd15, "to_err");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ERR,      16'd15, "to_sticky");
    step(0, 2, 0, 2, 1, 0, 0, 0, 1, 0, LU | ERR, 16'd15, "lu_with_err");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ERR,      16'd16, "lu_with_err_after");
    // reset in the middle of MD_WAIT, then relaunch
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, START | ERR, 16'd16, "rs_launch");
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, WAITS | ERR, 16'd17, "rs_wait1");
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, WAITS | ERR, 16'd18, "rs_wait2");
    step(1, 0, 0, 0, 0, 0, 1, 0, 1, 1, NONE,  16'd0, "rs_in_reset");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE,  16'd0, "rs_idle");
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, START, 16'd0, "rs_relaunch");
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, WAITS, 16'd1, "rs_wait");
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, DONE,  16'd2, "rs_done");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE,  16'd2, "rs_final");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
